// File: rtl/localbus_master_pkg.sv
// Shared types and localbus field constants for the localbus command initiator.
package localbus_master_pkg;

  localparam int unsigned LB_DATA_W          = 32;
  localparam int unsigned LB_SEL_MSB         = 18;
  localparam int unsigned LB_SEL_LSB         = 16;
  localparam logic        LB_RD              = 1'b1;
  localparam logic        LB_WR              = 1'b0;
  localparam int unsigned LB_TIMEOUT_DEFAULT = 256;
  localparam int unsigned LB_CNT_W_DEFAULT   = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ALE     = 3'd1,
    ST_DATA    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RESP    = 3'd4
  } lb_state_e;

  // Command fields that must outlive the accept cycle.
  typedef struct packed {
    logic                 rd_wr;
    logic [LB_DATA_W-1:0] wdata;
  } lb_cmd_t;

endpackage

// File: rtl/localbus_master.sv
// Single-outstanding localbus initiator: ALE address phase, chip-select data phase,
// ack handshake with per-edge timeout, one-cycle response strobe.
module localbus_master
  import localbus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LB_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W          = LB_CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_rd_wr,
  input  logic [LB_DATA_W-1:0] cmd_addr,
  input  logic [LB_DATA_W-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [LB_DATA_W-1:0] rsp_rdata,
  output logic                 rsp_timeout,
  output logic                 localbus_cs_n,
  output logic                 localbus_rd_wr,
  output logic [LB_DATA_W-1:0] localbus_data,
  output logic                 localbus_ale,
  input  logic                 localbus_ack_n,
  input  logic [LB_DATA_W-1:0] localbus_data_out
);

  lb_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 cnt_hit;
  lb_cmd_t              cmd_q, cmd_d;
  logic                 to_flag_q, to_flag_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [LB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic                 cs_n_q, cs_n_d;
  logic                 rd_wr_q, rd_wr_d;
  logic [LB_DATA_W-1:0] lb_data_q, lb_data_d;
  logic                 ale_q, ale_d;

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign cnt_hit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // Next state, then every registered output decoded from the next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    to_flag_d   = to_flag_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_d.rd_wr = cmd_rd_wr;
          cmd_d.wdata = cmd_wdata;
          to_flag_d   = 1'b0;
          rsp_rdata_d = '0;
          cnt_d       = '0;
          state_d     = ST_ALE;
        end
      end
      ST_ALE: begin
        cnt_d   = '0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (!localbus_ack_n) begin
          rsp_rdata_d = (cmd_q.rd_wr == LB_RD) ? localbus_data_out : '0;
          cnt_d       = '0;
          state_d     = ST_RELEASE;
        end else if (cnt_hit) begin
          to_flag_d   = 1'b1;
          rsp_rdata_d = '0;
          cnt_d       = '0;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RELEASE: begin
        if (localbus_ack_n) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end else if (cnt_hit) begin
          to_flag_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESP: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d   = (state_d == ST_IDLE);
    ale_d         = (state_d == ST_ALE);
    cs_n_d        = (state_d != ST_DATA);
    rsp_valid_d   = (state_d == ST_RESP);
    rsp_timeout_d = (state_d == ST_RESP) && to_flag_d;
    rd_wr_d       = LB_RD;
    lb_data_d     = '0;

    // ALE is only ever entered from an accept, so the address comes straight off the command port.
    if (state_d == ST_ALE) begin
      rd_wr_d   = cmd_d.rd_wr;
      lb_data_d = cmd_addr;
    end else if (state_d == ST_DATA || state_d == ST_RELEASE) begin
      rd_wr_d = cmd_d.rd_wr;
      if (state_d == ST_DATA && cmd_d.rd_wr == LB_WR) begin
        lb_data_d = cmd_d.wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cmd_q         <= '0;
      to_flag_q     <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      cs_n_q        <= 1'b1;
      rd_wr_q       <= LB_RD;
      lb_data_q     <= '0;
      ale_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      to_flag_q     <= to_flag_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      cs_n_q        <= cs_n_d;
      rd_wr_q       <= rd_wr_d;
      lb_data_q     <= lb_data_d;
      ale_q         <= ale_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign localbus_cs_n  = cs_n_q;
  assign localbus_rd_wr = rd_wr_q;
  assign localbus_data  = lb_data_q;
  assign localbus_ale   = ale_q;

endmodule

// File: tb/tb_localbus_master.sv
// Bench for localbus_master: scripted and randomized responders, checked against a
// transaction-level timing/data model.
module tb_localbus_master;

  localparam int unsigned TO    = 8;
  localparam int unsigned CW    = 4;
  localparam int          NEVER = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rd_wr = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        localbus_cs_n;
  logic        localbus_rd_wr;
  logic [31:0] localbus_data;
  logic        localbus_ale;
  logic        localbus_ack_n = 1'b1;
  logic [31:0] localbus_data_out = '0;

  localbus_master #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .localbus_cs_n(localbus_cs_n), .localbus_rd_wr(localbus_rd_wr),
    .localbus_data(localbus_data), .localbus_ale(localbus_ale),
    .localbus_ack_n(localbus_ack_n), .localbus_data_out(localbus_data_out)
  );

  always #5 clk = ~clk;

  // d: DATA cycles before the responder acks; h: cycles ack stays low; pre: ack already low in ALE.
  typedef struct { bit rd; logic [31:0] addr, wdata, rdata; int d, h; bit pre; } cmd_t;
  typedef struct {
    int acc_cyc, ale_cyc, ale_len, cs_cyc, cs_low, rsp_cnt, rsp_cyc;
    logic [31:0] ale_data, cs_data, rsp_rdata;
    logic ale_rdwr, cs_rdwr, rsp_to;
    bit cs_var;
  } obs_t;
  typedef struct { int cs_low, lat; bit to; logic [31:0] rdata, cs_data; } exp_t;

  cmd_t cmds[$];
  obs_t obs[$];
  int   n_ale, n_stray, checks, errors;
  bit   run_expired;

  function automatic cmd_t mk_cmd(bit rd, logic [31:0] addr, logic [31:0] wdata,
                                  logic [31:0] rdata, int d, int h, bit pre);
    cmd_t c;
    c.rd = rd; c.addr = addr; c.wdata = wdata; c.rdata = rdata; c.d = d; c.h = h; c.pre = pre;
    return c;
  endfunction

  // Transaction-level expectation: chip-select length, response latency from accept, result.
  function automatic exp_t model(cmd_t c);
    exp_t e;
    int rel;
    e.cs_data = c.rd ? 32'h0 : c.wdata;
    if (c.d >= int'(TO)) begin
      e.cs_low = int'(TO); rel = 0; e.to = 1'b1; e.rdata = 32'h0;
    end else begin
      e.cs_low = c.d + 1;
      e.rdata  = c.rd ? c.rdata : 32'h0;
      if (c.h - 1 >= int'(TO)) begin rel = int'(TO); e.to = 1'b1; end
      else begin rel = c.h; e.to = 1'b0; end
    end
    e.lat = 1 + e.cs_low + rel + 1;
    return e;
  endfunction

  // Presents the queued commands with cmd_valid held, plays the responder, records what the bus did.
  task automatic run_cmds();
    int n = cmds.size();
    int k = 0, issued = 0, cur = -1, seen_cs = 0, low_cnt = 0, tail = -1;
    int budget = 40 * n + 40;
    bit prev_ale = 1'b0, acked = 1'b0;
    obs_t o0;
    o0 = '{default: 0};
    obs.delete();
    for (int i = 0; i < n; i++) obs.push_back(o0);
    n_ale = 0; n_stray = 0; run_expired = 1'b0;
    @(negedge clk);
    forever begin
      if (localbus_ale && !prev_ale) begin
        cur++; n_ale++; seen_cs = 0; acked = 1'b0; low_cnt = 0;
        if (cur < n) begin
          obs[cur].ale_cyc = k; obs[cur].ale_data = localbus_data; obs[cur].ale_rdwr = localbus_rd_wr;
        end
      end
      if (localbus_ale && cur >= 0 && cur < n) obs[cur].ale_len++;
      prev_ale = localbus_ale;
      if (!localbus_cs_n && cur >= 0 && cur < n) begin
        seen_cs++;
        if (obs[cur].cs_low == 0) begin
          obs[cur].cs_cyc = k; obs[cur].cs_data = localbus_data; obs[cur].cs_rdwr = localbus_rd_wr;
        end else if (localbus_data !== obs[cur].cs_data) obs[cur].cs_var = 1'b1;
        obs[cur].cs_low++;
      end
      if (rsp_valid) begin
        if (cur >= 0 && cur < n) begin
          obs[cur].rsp_cnt++; obs[cur].rsp_cyc = k;
          obs[cur].rsp_to = rsp_timeout; obs[cur].rsp_rdata = rsp_rdata;
          if (cur == n - 1) tail = k + 3;
        end else n_stray++;
        acked = 1'b0;
      end
      if (acked) begin
        if (low_cnt < cmds[cur].h) begin localbus_ack_n = 1'b0; low_cnt++; end
        else localbus_ack_n = 1'b1;
        localbus_data_out = $urandom;
      end else if (cur >= 0 && cur < n && !localbus_cs_n && seen_cs == cmds[cur].d + 1) begin
        localbus_ack_n = 1'b0; localbus_data_out = cmds[cur].rdata; acked = 1'b1; low_cnt = 1;
      end else if (cur >= 0 && cur < n && localbus_ale && cmds[cur].pre) begin
        localbus_ack_n = 1'b0; localbus_data_out = $urandom;
      end else begin
        localbus_ack_n = 1'b1; localbus_data_out = $urandom;
      end
      if (issued < n) begin
        cmd_valid = 1'b1; cmd_rd_wr = cmds[issued].rd;
        cmd_addr = cmds[issued].addr; cmd_wdata = cmds[issued].wdata;
        if (cmd_ready) begin obs[issued].acc_cyc = k; issued++; end
      end else cmd_valid = 1'b0;
      if (k == tail) break;
      if (k >= budget) begin run_expired = 1'b1; break; end
      @(negedge clk);
      k++;
    end
    cmd_valid = 1'b0;
    localbus_ack_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if (localbus_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b exp 1", localbus_cs_n); end
    checks++; if (localbus_ale !== 1'b0) begin errors++; $display("FAIL reset_ale got %b exp 0", localbus_ale); end
    checks++; if (localbus_rd_wr !== 1'b1) begin errors++; $display("FAIL reset_rd_wr got %b exp 1", localbus_rd_wr); end
    checks++; if (localbus_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", localbus_data); end
    checks++; if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL reset_rsp got %b/%b exp 0/0", rsp_valid, rsp_timeout); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_write();
    exp_t e;
    cmds.delete();
    cmds.push_back(mk_cmd(1'b0, 32'h0001_0004, 32'hDEAD_BEEF, 32'h0, 3, 1, 1'b0));
    run_cmds();
    e = model(cmds[0]);
    checks++; if (run_expired) begin errors++; $display("FAIL wr_expired got 1 exp 0"); end
    checks++; if (obs[0].ale_len != 1 || obs[0].ale_cyc != obs[0].acc_cyc + 1) begin errors++; $display("FAIL wr_ale len/cyc got %0d/%0d exp 1/%0d", obs[0].ale_len, obs[0].ale_cyc, obs[0].acc_cyc + 1); end
    checks++; if (obs[0].ale_data !== 32'h0001_0004) begin errors++; $display("FAIL wr_ale_data got %h exp 00010004", obs[0].ale_data); end
    checks++; if (obs[0].cs_low != 4 || obs[0].cs_cyc != obs[0].acc_cyc + 2) begin errors++; $display("FAIL wr_cs low/start got %0d/%0d exp 4/%0d", obs[0].cs_low, obs[0].cs_cyc, obs[0].acc_cyc + 2); end
    checks++; if (obs[0].cs_data !== 32'hDEAD_BEEF || obs[0].cs_var) begin errors++; $display("FAIL wr_cs_data got %h var %0b exp deadbeef", obs[0].cs_data, obs[0].cs_var); end
    checks++; if (obs[0].rsp_cnt != 1 || obs[0].rsp_to !== 1'b0 || obs[0].rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rsp got cnt %0d to %b rdata %h exp 1/0/0", obs[0].rsp_cnt, obs[0].rsp_to, obs[0].rsp_rdata); end
    checks++; if (obs[0].rsp_cyc != obs[0].acc_cyc + e.lat) begin errors++; $display("FAIL wr_latency got %0d exp %0d", obs[0].rsp_cyc - obs[0].acc_cyc, e.lat); end
  endtask

  task automatic test_read();
    cmds.delete();
    cmds.push_back(mk_cmd(1'b1, 32'h0003_0010, $urandom, 32'h1234_5678, 2, 2, 1'b0));
    run_cmds();
    checks++; if (obs[0].rsp_rdata !== 32'h1234_5678 || obs[0].rsp_to !== 1'b0) begin errors++; $display("FAIL rd_rsp got %h to %b exp 12345678/0", obs[0].rsp_rdata, obs[0].rsp_to); end
    checks++; if (obs[0].cs_data !== 32'h0 || obs[0].cs_var || obs[0].cs_rdwr !== 1'b1) begin errors++; $display("FAIL rd_data_phase got %h var %0b rdwr %b exp 0/0/1", obs[0].cs_data, obs[0].cs_var, obs[0].cs_rdwr); end
    checks++; if (obs[0].ale_data !== 32'h0003_0010 || obs[0].ale_rdwr !== 1'b1) begin errors++; $display("FAIL rd_ale got %h/%b exp 00030010/1", obs[0].ale_data, obs[0].ale_rdwr); end
  endtask

  task automatic test_pre_ack();
    logic [31:0] v = $urandom;
    cmds.delete();
    cmds.push_back(mk_cmd(1'b1, $urandom, $urandom, v, 0, 2, 1'b1));
    run_cmds();
    checks++; if (obs[0].cs_low != 1 || obs[0].rsp_rdata !== v || obs[0].rsp_to !== 1'b0) begin errors++; $display("FAIL pre_ack got cs %0d rdata %h to %b exp 1/%h/0", obs[0].cs_low, obs[0].rsp_rdata, obs[0].rsp_to, v); end
  endtask

  task automatic test_no_responder();
    exp_t e;
    cmds.delete();
    cmds.push_back(mk_cmd(1'b1, $urandom, $urandom, $urandom, NEVER, 1, 1'b0));
    run_cmds();
    e = model(cmds[0]);
    checks++; if (obs[0].cs_low != int'(TO)) begin errors++; $display("FAIL noresp_cs_low got %0d exp %0d", obs[0].cs_low, TO); end
    checks++; if (obs[0].rsp_cnt != 1 || obs[0].rsp_to !== 1'b1 || obs[0].rsp_rdata !== 32'h0) begin errors++; $display("FAIL noresp_rsp got cnt %0d to %b rdata %h exp 1/1/0", obs[0].rsp_cnt, obs[0].rsp_to, obs[0].rsp_rdata); end
    checks++; if (obs[0].rsp_cyc != obs[0].acc_cyc + e.lat) begin errors++; $display("FAIL noresp_latency got %0d exp %0d", obs[0].rsp_cyc - obs[0].acc_cyc, e.lat); end
  endtask

  task automatic test_stuck_ack();
    exp_t e;
    cmds.delete();
    cmds.push_back(mk_cmd(1'b1, $urandom, $urandom, 32'hA5A5_A5A5, 1, NEVER, 1'b0));
    run_cmds();
    e = model(cmds[0]);
    checks++; if (obs[0].rsp_to !== 1'b1 || obs[0].rsp_rdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL stuck_rsp got to %b rdata %h exp 1/a5a5a5a5", obs[0].rsp_to, obs[0].rsp_rdata); end
    checks++; if (obs[0].rsp_cyc != obs[0].acc_cyc + e.lat) begin errors++; $display("FAIL stuck_latency got %0d exp %0d", obs[0].rsp_cyc - obs[0].acc_cyc, e.lat); end
  endtask

  task automatic test_back_to_back();
    cmds.delete();
    cmds.push_back(mk_cmd(1'b0, 32'h0002_0100, $urandom, 32'h0, 1, 1, 1'b0));
    cmds.push_back(mk_cmd(1'b1, 32'h0005_0200, $urandom, $urandom, 0, 1, 1'b0));
    run_cmds();
    checks++; if (n_ale != 2 || n_stray != 0) begin errors++; $display("FAIL b2b_ale_count got %0d stray %0d exp 2/0", n_ale, n_stray); end
    checks++; if (obs[0].ale_data !== 32'h0002_0100 || obs[1].ale_data !== 32'h0005_0200) begin errors++; $display("FAIL b2b_order got %h,%h exp 00020100,00050200", obs[0].ale_data, obs[1].ale_data); end
    checks++; if (obs[1].acc_cyc != obs[0].rsp_cyc + 1) begin errors++; $display("FAIL b2b_second_accept got %0d exp %0d", obs[1].acc_cyc, obs[0].rsp_cyc + 1); end
    checks++; if (obs[0].rsp_cnt != 1 || obs[1].rsp_cnt != 1) begin errors++; $display("FAIL b2b_rsp_count got %0d,%0d exp 1,1", obs[0].rsp_cnt, obs[1].rsp_cnt); end
  endtask

  task automatic test_async_reset();
    int n_rsp = 0;
    bit ready_ok = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rd_wr = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; localbus_ack_n = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 10 && localbus_cs_n; i++) @(negedge clk);
    checks++; if (localbus_cs_n !== 1'b0) begin errors++; $display("FAIL arst_reach_data got cs_n %b exp 0", localbus_cs_n); end
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (localbus_cs_n !== 1'b1 || localbus_ale !== 1'b0) begin errors++; $display("FAIL arst_immediate got cs_n %b ale %b exp 1/0", localbus_cs_n, localbus_ale); end
    repeat (2) begin @(negedge clk); if (rsp_valid) n_rsp++; end
    reset = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
      if (cmd_ready !== 1'b1) ready_ok = 1'b0;
    end
    checks++; if (n_rsp != 0) begin errors++; $display("FAIL arst_no_rsp got %0d exp 0", n_rsp); end
    checks++; if (!ready_ok) begin errors++; $display("FAIL arst_cmd_ready got 0 exp 1"); end
  endtask

  task automatic test_random();
    exp_t e;
    int d, h;
    cmds.delete();
    for (int i = 0; i < 24; i++) begin
      d = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 9));
      h = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(1, 10));
      cmds.push_back(mk_cmd($urandom_range(0, 1) == 1, $urandom, $urandom, $urandom, d, h,
                            (d == 0) && ($urandom_range(0, 1) == 1)));
    end
    run_cmds();
    checks++; if (run_expired || n_ale != 24 || n_stray != 0) begin errors++; $display("FAIL rand_run got expired %0b ale %0d stray %0d exp 0/24/0", run_expired, n_ale, n_stray); end
    for (int i = 0; i < 24; i++) begin
      e = model(cmds[i]);
      checks++; if (i > 0 && obs[i].acc_cyc != obs[i-1].rsp_cyc + 1) begin errors++; $display("FAIL rand[%0d] accept got %0d exp %0d", i, obs[i].acc_cyc, obs[i-1].rsp_cyc + 1); end
      checks++; if (obs[i].ale_data !== cmds[i].addr || obs[i].ale_rdwr !== cmds[i].rd || obs[i].ale_len != 1) begin errors++; $display("FAIL rand[%0d] ale got %h/%b/%0d exp %h/%b/1", i, obs[i].ale_data, obs[i].ale_rdwr, obs[i].ale_len, cmds[i].addr, cmds[i].rd); end
      checks++; if (obs[i].cs_low != e.cs_low || obs[i].cs_data !== e.cs_data || obs[i].cs_var) begin errors++; $display("FAIL rand[%0d] data_phase got %0d/%h var %0b exp %0d/%h", i, obs[i].cs_low, obs[i].cs_data, obs[i].cs_var, e.cs_low, e.cs_data); end
      checks++; if (obs[i].rsp_cnt != 1 || obs[i].rsp_to !== e.to || obs[i].rsp_rdata !== e.rdata) begin errors++; $display("FAIL rand[%0d] rsp got cnt %0d to %b rdata %h exp 1/%b/%h", i, obs[i].rsp_cnt, obs[i].rsp_to, obs[i].rsp_rdata, e.to, e.rdata); end
      checks++; if (obs[i].rsp_cyc != obs[i].acc_cyc + e.lat) begin errors++; $display("FAIL rand[%0d] latency got %0d exp %0d", i, obs[i].rsp_cyc - obs[i].acc_cyc, e.lat); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write();
    test_read();
    test_pre_ack();
    test_no_responder();
    test_stuck_ack();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/localbus_master.md
Name: localbus_master

Overview:
- Localbus initiator that turns single-beat configuration commands (rule/BV table writes, readback) into localbus transactions toward the lookup block's search engines.
- Sits between the host/control-plane command source and the lookup block's localbus slave port.
- One transaction in flight at a time, with an ack timeout so a missing or stuck responder cannot hang the control path.

Parameters:
- TIMEOUT_CYCLES, 256: maximum cycles to wait for each ack_n edge before the transaction is aborted.
- CNT_W, 9: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  single clock domain.
- reset  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  master can accept a command (high only in IDLE).
- cmd_rd_wr  input  1  1 = read, 0 = write.
- cmd_addr  input  32  address word; bits [18:16] select the engine.
- cmd_wdata  input  32  write data (ignored for reads).
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  32  read data captured at ack; 0 for writes and on timeout.
- rsp_timeout  output  1  qualifies rsp_valid; the transaction was aborted.
- localbus_cs_n  output  1  chip select, active low.
- localbus_rd_wr  output  1  transaction direction.
- localbus_data  output  32  address in the ALE phase, write data in the DATA phase.
- localbus_ale  output  1  address latch enable, one-cycle pulse.
- localbus_ack_n  input  1  responder acknowledge, active low.
- localbus_data_out  input  32  responder read data, valid while ack_n is low.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE.
  - cs_n = 1, ale = 0, rd_wr = 1, localbus_data = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_timeout = 0.
  - cmd_ready = 1 once the state is IDLE; the timeout counter clears.
- Reset mid-transaction: drop to IDLE immediately; no response is issued.
- All localbus outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch rd_wr/addr/wdata and go to ALE.
- ALE (exactly 1 cycle):
  - ale = 1, localbus_data = latched addr, rd_wr = latched value, cs_n = 1.
  - Next state: DATA.
- DATA:
  - ale = 0, cs_n = 0.
  - localbus_data = wdata for writes, 0 for reads.
  - The counter increments each cycle.
  - When ack_n is sampled 0: capture localbus_data_out into rsp_rdata for reads (0 for writes), set cs_n = 1 next cycle, clear the counter, go to RELEASE.
  - When the counter reaches TIMEOUT_CYCLES with no ack: cs_n = 1, set the timeout flag, rdata = 0, go to RESP.
- RELEASE:
  - cs_n = 1; wait for ack_n sampled 1, then go to RESP.
  - If ack_n stays low for TIMEOUT_CYCLES: set the timeout flag (rdata kept), go to RESP.
- RESP (1 cycle):
  - rsp_valid = 1, rsp_timeout = flag.
  - Next state IDLE. cmd_ready rises the following cycle, so there are no back-to-back accepts.
- Latency, write with a same-cycle responder:
  - accept at T0, ale at T1, cs_n low from T2.
  - ack seen at Tk gives cs_n high at Tk+1.
  - ack release seen gives rsp_valid the cycle after.
- Simultaneous events:
  - ack_n already low when entering DATA counts as an ack at the first DATA sample.
  - cmd_valid during a busy period is ignored (cmd_ready = 0); the command is not lost as long as the source holds cmd_valid.
- localbus_data_out is sampled only in DATA on the ack cycle; all other values are ignored.

Decomposition:
- Shared package:
  - state enum (IDLE, ALE, DATA, RELEASE, RESP).
  - localbus field constants: LB_SEL_MSB = 18, LB_SEL_LSB = 16, LB_RD = 1, LB_WR = 0.
  - default TIMEOUT_CYCLES.
- No sub-module required; the counter is inline. The command source is expected to be a FIFO outside this block.

Test Plan:
- Write: cmd addr = 0x0001_0004, wdata = 0xDEAD_BEEF, rd_wr = 0; responder acks 3 cycles after cs_n falls.
  - ale pulses 1 cycle with data = 0x0001_0004.
  - cs_n is low 4 cycles with data = 0xDEAD_BEEF.
  - rsp_valid with timeout = 0 and rdata = 0.
- Read: addr = 0x0003_0010; responder returns 0x1234_5678 with ack.
  - rsp_rdata = 0x1234_5678, rsp_timeout = 0.
  - localbus_data = 0 during DATA.
- No responder (ack_n held 1): TIMEOUT_CYCLES = 8.
  - cs_n deasserts after 8 DATA cycles.
  - rsp_valid = 1, rsp_timeout = 1, rdata = 0.
- Stuck ack (ack_n held 0 after acking): read with data 0xA5A5_A5A5.
  - RELEASE times out.
  - rsp_timeout = 1, rsp_rdata = 0xA5A5_A5A5.
- Back-to-back: cmd_valid held high with two queued commands.
  - Second accept occurs only after rsp_valid plus 1 cycle.
  - Exactly two ale pulses, in command order.
- Async reset asserted in DATA of a write.
  - cs_n = 1 and ale = 0 immediately.
  - No rsp_valid.
  - cmd_ready = 1 after reset release.
